// File: rtl/nightlight_pkg.sv
// Shared types and constants for the nightlight sequencing controller.
package nightlight_pkg;

  localparam int TMR_W = 24;

  // Each hh/mm/ss pair presets to 5,9.
  localparam logic [3:0]       BCD_TENS_MAX = 4'd5;
  localparam logic [3:0]       BCD_ONES_MAX = 4'd9;
  localparam logic [TMR_W-1:0] TMR_PRESET   = {3{BCD_TENS_MAX, BCD_ONES_MAX}};

  typedef enum logic [2:0] {
    DAY     = 3'd0,
    LOAD    = 3'd1,
    ON      = 3'd2,
    WARN    = 3'd3,
    EXPIRED = 3'd4
  } nl_state_e;

endpackage

// File: rtl/nightlight_if.sv
// Controller <-> countdown timer bus: preset strobe, count enable, BCD readback.
interface nightlight_if;
  import nightlight_pkg::*;

  logic [TMR_W-1:0] tmr_bcd;
  logic             tmr_set;
  logic             tmr_en;

  modport master (output tmr_set, tmr_en, input  tmr_bcd);
  modport slave  (input  tmr_set, tmr_en, output tmr_bcd);
endinterface

// File: rtl/nl_debounce.sv
// Ambient-dark conditioning: 2-flop synchronizer plus a tick-sampled filter.
module nl_debounce #(
  parameter int DEB_TICKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic filt
);

  logic [1:0] sync;
  logic [3:0] cnt;

  // cnt counts consecutive disagreeing samples; one agreeing sample restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      cnt  <= '0;
      filt <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (tick) begin
        if (sync[1] == filt) begin
          cnt <= '0;
        end else if (cnt == 4'(DEB_TICKS - 1)) begin
          filt <= sync[1];
          cnt  <= '0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/nightlight_ctrl.sv
// Nightlight sequencer: debounced dark/button in, timer preset/enable and lamp out.
// Define NIGHTLIGHT_WARN_BLINK_EN to blink the lamp on each tick while in WARN.
module nightlight_ctrl
  import nightlight_pkg::*;
#(
  parameter logic [7:0] WARN_SECS = 8'h30,
  parameter int          DEB_TICKS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         dark_in,
  input  logic         btn_in,
  nightlight_if.master tbus,
  output logic         lamp,
  output logic [2:0]   state_o
);

  nl_state_e  state;
  logic [1:0] bsync;
  logic       btn_d, btn_rise;
  logic       dark_f, dark_q, dark_rise;
  logic       fresh, set_q;
  logic       tmr_zero, tmr_warn;
`ifdef NIGHTLIGHT_WARN_BLINK_EN
  logic       phase;
`endif

  nl_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick),
    .raw  (dark_in),
    .filt (dark_f)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bsync    <= '0;
      btn_d    <= 1'b0;
      btn_rise <= 1'b0;
      dark_q   <= 1'b0;
    end else begin
      bsync    <= {bsync[0], btn_in};
      btn_d    <= bsync[1];
      btn_rise <= bsync[1] & ~btn_d;
      dark_q   <= dark_f;
    end
  end

  assign dark_rise = dark_f & ~dark_q;

  // Both sides are BCD, so a plain unsigned compare orders them correctly.
  assign tmr_zero = (tbus.tmr_bcd == '0);
  assign tmr_warn = (tbus.tmr_bcd[TMR_W-1:8] == '0) && (tbus.tmr_bcd[7:0] <= WARN_SECS);

  assign tbus.tmr_en  = tick & ((state == ON) | (state == WARN)) & ~tmr_zero;
  assign tbus.tmr_set = set_q;
  assign state_o      = state;

  // fresh marks the first ON cycle after LOAD, when the timer readback is still stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DAY;
      lamp  <= 1'b0;
      set_q <= 1'b0;
      fresh <= 1'b0;
`ifdef NIGHTLIGHT_WARN_BLINK_EN
      phase <= 1'b0;
`endif
    end else begin
      set_q <= 1'b0;
      fresh <= 1'b0;
      case (state)
        DAY: begin
          if (dark_rise) begin
            state <= LOAD; set_q <= 1'b1; lamp <= 1'b1;
          end
        end
        LOAD: begin
          state <= ON; lamp <= 1'b1; fresh <= 1'b1;
        end
        ON: begin
          if (!dark_f) begin
            state <= DAY; lamp <= 1'b0;
          end else if (btn_rise) begin
            state <= LOAD; set_q <= 1'b1; lamp <= 1'b1;
          end else if (!fresh && tmr_warn) begin
            state <= WARN;
`ifdef NIGHTLIGHT_WARN_BLINK_EN
            phase <= 1'b0;
            lamp  <= 1'b0;
`else
            lamp  <= 1'b1;
`endif
          end
        end
        WARN: begin
          if (!dark_f) begin
            state <= DAY; lamp <= 1'b0;
          end else if (btn_rise) begin
            state <= LOAD; set_q <= 1'b1; lamp <= 1'b1;
          end else if (tmr_zero) begin
            state <= EXPIRED; lamp <= 1'b0;
          end else begin
`ifdef NIGHTLIGHT_WARN_BLINK_EN
            if (tick) begin
              phase <= ~phase;
              lamp  <= ~phase;
            end
`else
            lamp <= 1'b1;
`endif
          end
        end
        EXPIRED: begin
          if (!dark_f) begin
            state <= DAY; lamp <= 1'b0;
          end else if (btn_rise) begin
            state <= LOAD; set_q <= 1'b1; lamp <= 1'b1;
          end
        end
        default: begin
          state <= DAY; lamp <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nightlight_ctrl.sv
// Bench for nightlight_ctrl: directed scenarios then random traffic against a history-based model.
module tb_nightlight_ctrl;

  localparam int S_DAY = 0, S_LOAD = 1, S_ON = 2, S_WARN = 3, S_EXP = 4;
  localparam int DEB      = 4;
  localparam int WARN_S   = 30;
  localparam int PRESET_S = 59*3600 + 59*60 + 59;

  logic       clk = 1'b0;
  logic       rst_n, tick, dark_in, btn_in;
  logic       lamp;
  logic [2:0] state_o;
  int         secs;
  int         nvec = 0, nerr = 0;

  nightlight_if tif();

  nightlight_ctrl #(.WARN_SECS(8'h30), .DEB_TICKS(DEB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (tick),
    .dark_in(dark_in),
    .btn_in (btn_in),
    .tbus   (tif),
    .lamp   (lamp),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, x;
    h = s / 3600; m = (s / 60) % 60; x = s % 60;
    return {4'(h/10), 4'(h%10), 4'(m/10), 4'(m%10), 4'(x/10), 4'(x%10)};
  endfunction

  // Timer stand-in: seconds counter presented as BCD.
  assign tif.tmr_bcd = to_bcd(secs);

  // Reference model: raw input histories, newest at bit 0 (bit k = value k+1 cycles ago).
  int       m_st, m_st_prev, m_run, m_wt;
  bit       m_dark, m_dark_prev;
  bit [3:0] dh, bh;

  function automatic void m_init();
    m_st = S_DAY; m_st_prev = S_DAY; m_run = 0; m_wt = 0;
    m_dark = 1'b0; m_dark_prev = 1'b0; dh = '0; bh = '0;
  endfunction

  function automatic int m_next();
    bit rise, fresh, warn, zero;
    rise  = bh[2] & ~bh[3];
    fresh = (m_st_prev == S_LOAD);
    warn  = (secs <= WARN_S);
    zero  = (secs == 0);
    case (m_st)
      S_DAY:  return (m_dark && !m_dark_prev) ? S_LOAD : S_DAY;
      S_LOAD: return S_ON;
      S_ON:   return !m_dark ? S_DAY : rise ? S_LOAD : (!fresh && warn) ? S_WARN : S_ON;
      S_WARN: return !m_dark ? S_DAY : rise ? S_LOAD : zero ? S_EXP : S_WARN;
      default: return !m_dark ? S_DAY : rise ? S_LOAD : S_EXP;
    endcase
  endfunction

  function automatic void m_step(input bit t, input bit d, input bit b);
    int nxt;
    nxt = m_next();
    if (nxt == S_WARN) m_wt = (m_st == S_WARN) ? m_wt + int'(t) : 0;
    m_st_prev = m_st; m_st = nxt;
    m_dark_prev = m_dark;
    if (t) begin
      if (dh[1] == m_dark) m_run = 0;
      else begin
        m_run++;
        if (m_run == DEB) begin m_dark = dh[1]; m_run = 0; end
      end
    end
    dh = {dh[2:0], d};
    bh = {bh[2:0], b};
  endfunction

  function automatic bit m_lamp();
    case (m_st)
      S_ON: return 1'b1;
`ifdef NIGHTLIGHT_WARN_BLINK_EN
      S_WARN: return (m_wt % 2) == 1;
`else
      S_WARN: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check tmr_en before the edge, registered outputs after it.
  task automatic cyc(input bit t, input bit d, input bit b);
    bit set_q, en_q;
    tick = t; dark_in = d; btn_in = b;
    #1;
    chk("tmr_en", tif.tmr_en, t && (m_st == S_ON || m_st == S_WARN) && secs != 0);
    set_q = tif.tmr_set; en_q = tif.tmr_en;
    @(posedge clk); #1;
    m_step(t, d, b);
    if (set_q) secs = PRESET_S;
    else if (en_q && secs > 0) secs--;
    chk("state", state_o, m_st);
    chk("tmr_set", tif.tmr_set, m_st == S_LOAD);
    if (m_st != S_LOAD) chk("lamp", lamp, m_lamp());
    @(negedge clk);
  endtask

  task automatic run(input int n, input int per, input bit d, input bit b);
    for (int i = 0; i < n; i++) cyc(per != 0 && (i % per) == per - 1, d, b);
  endtask

  task automatic do_reset(input bit t);
    rst_n = 1'b0; tick = t;
    #1;
    chk("rst_lamp", lamp, 0);
    chk("rst_en", tif.tmr_en, 0);
    chk("rst_set", tif.tmr_set, 0);
    chk("rst_state", state_o, 0);
    m_init();
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1; tick = 1'b0;
  endtask

  initial begin
    bit dr, br;
    rst_n = 1'b0; tick = 1'b0; dark_in = 1'b0; btn_in = 1'b0; secs = 0;
    m_init();
    @(negedge clk);
    do_reset(1'b0);

    // Three-tick dark glitch must not pass the filter.
    run(4, 0, 0, 0);
    run(12, 4, 1, 0);
    run(24, 4, 0, 0);
    chk("glitch_day", state_o, S_DAY);

    // Sustained dark: LOAD, then ON with ticks counting.
    run(40, 4, 1, 0);
    chk("dark_on", state_o, S_ON);
    chk("dark_lamp", lamp, 1);

    // Count down through WARN into EXPIRED.
    secs = 31;
    run(160, 4, 1, 0);
    chk("expired", state_o, S_EXP);
    chk("exp_secs", secs, 0);

    // Relight, drop into WARN, extend at 00:00:12.
    run(8, 0, 1, 1);
    run(4, 0, 1, 0);
    secs = 15;
    for (int i = 0; i < 100 && secs != 12; i++) cyc((i % 4) == 3, 1, 0);
    chk("warn_at12", state_o, S_WARN);
    run(8, 0, 1, 1);
    chk("extend_on", state_o, S_ON);
    chk("extend_preset", tif.tmr_bcd, 24'h595959);
    run(4, 0, 1, 0);

    // Dark drop with a simultaneous button press: dark wins after filtering.
    run(40, 4, 0, 1);
    chk("drop_day", state_o, S_DAY);
    chk("drop_lamp", lamp, 0);
    run(4, 0, 0, 0);

    // Reset asserted in WARN while a tick is present.
    run(40, 4, 1, 0);
    secs = 25;
    run(3, 0, 1, 0);
    chk("pre_rst_warn", state_o, S_WARN);
    do_reset(1'b1);
    run(2, 0, 0, 0);
    chk("post_rst_state", state_o, 0);

    // Random traffic.
    dr = 1'b0; br = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) dr = ~dr;
      if ($urandom_range(0, 11) == 0) br = ~br;
      if ($urandom_range(0, 149) == 0) secs = $urandom_range(0, 40);
      if ($urandom_range(0, 799) == 0) do_reset(1'($urandom_range(0, 1)));
      else cyc($urandom_range(0, 2) == 0, dr, br);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
